// File: rtl/crop_frame_arbiter_if.sv
// Handshake bundle between the pixel sources, the frame arbiter and the crop datapath.
// The master modport is the arbiter's view; the slave modport is the surrounding environment.
interface crop_frame_arbiter_if #(
  parameter int PIXEL_BIT_WIDTH = 12,
  parameter int NUM_SRC         = 4
);
  localparam int ID_W = $clog2(NUM_SRC);

  logic [NUM_SRC*PIXEL_BIT_WIDTH-1:0] src_pixel;
  logic [NUM_SRC-1:0]                 src_valid;
  logic [NUM_SRC-1:0]                 src_ready;
  logic [PIXEL_BIT_WIDTH-1:0]         crop_pixel;
  logic                               crop_valid;
  logic                               crop_ready;
  logic [ID_W-1:0]                    crop_src_id;
  logic                               crop_sof;
  logic                               frame_done;
  logic                               busy;

  modport master (
    input  src_pixel, src_valid, crop_ready,
    output src_ready, crop_pixel, crop_valid, crop_src_id, crop_sof, frame_done, busy
  );

  modport slave (
    output src_pixel, src_valid, crop_ready,
    input  src_ready, crop_pixel, crop_valid, crop_src_id, crop_sof, frame_done, busy
  );
endinterface

// File: rtl/crop_frame_arbiter.sv
// Frame-granular round-robin arbiter: locks one source for a whole IN_ROWS x IN_COLS frame
// and passes its ready/valid pixel stream straight through to the shared crop datapath.
module crop_frame_arbiter #(
  parameter int PIXEL_BIT_WIDTH = 12,
  parameter int NUM_SRC         = 4,
  parameter int IN_ROWS         = 40,
  parameter int IN_COLS         = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  crop_frame_arbiter_if.master bus
);
  localparam int ID_W      = $clog2(NUM_SRC);
  localparam int FRAME_PIX = IN_ROWS * IN_COLS;
  localparam int CNT_W     = $clog2(FRAME_PIX);

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIX - 1);
  localparam logic [ID_W-1:0]  LAST_SRC = ID_W'(NUM_SRC - 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t                     state, state_next;
  logic [ID_W-1:0]            grant_id;
  logic [ID_W-1:0]            last_grant;
  logic [CNT_W-1:0]           pix_cnt;
  logic                       frame_done_q;
  logic [ID_W-1:0]            rr_idx;
  logic [ID_W-1:0]            rr_pick;
  logic                       rr_found;
  logic                       fwd_valid;
  logic                       xfer;
  logic                       last_xfer;
  logic [PIXEL_BIT_WIDTH-1:0] src_pix_arr [NUM_SRC];

  // Unpack the flat source bus so the granted pixel is a plain array lookup.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_pix_arr[i] = bus.src_pixel[i*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH];
    end
  end

  // Scan from the source after the last grant, wrapping, so every requester gets a turn.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = grant_id;
    rr_idx   = grant_id;
    for (int i = 1; i <= NUM_SRC; i++) begin
      rr_idx = ID_W'((int'(last_grant) + i) % NUM_SRC);
      if (!rr_found && bus.src_valid[rr_idx]) begin
        rr_found = 1'b1;
        rr_pick  = rr_idx;
      end
    end
  end

  assign fwd_valid = bus.src_valid[grant_id];
  assign xfer      = (state == LOCKED) && fwd_valid && bus.crop_ready;
  assign last_xfer = xfer && (pix_cnt == LAST_PIX);

  // NOTE: every output of this block gets a default before the case, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    bus.src_ready  = '0;
    bus.crop_valid = 1'b0;
    bus.crop_sof   = 1'b0;
    unique case (state)
      IDLE: begin
        if (rr_found) state_next = LOCKED;
      end
      LOCKED: begin
        bus.src_ready[grant_id] = bus.crop_ready;
        bus.crop_valid          = fwd_valid;
        bus.crop_sof            = fwd_valid && (pix_cnt == '0);
        if (last_xfer) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking <= so each one samples the pre-edge value of the
  // others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A reset mid-frame simply drops the partial frame: no frame_done is raised for it.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_id     <= '0;
      last_grant   <= LAST_SRC;
      pix_cnt      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= last_xfer;
      if (state == IDLE && rr_found) grant_id <= rr_pick;
      if (last_xfer) begin
        pix_cnt    <= '0;
        last_grant <= grant_id;
      end else if (xfer) begin
        pix_cnt <= pix_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.crop_pixel  = src_pix_arr[grant_id];
  assign bus.crop_src_id = grant_id;
  assign bus.frame_done  = frame_done_q;
  assign bus.busy        = (state == LOCKED);

endmodule

// File: tb/tb_crop_frame_arbiter.sv
// Directed bench for crop_frame_arbiter with 4 sources and 4x4 frames; each source's pixel
// carries its index in the top bits and a per-source sequence number below.
module tb_crop_frame_arbiter;
  localparam int PW    = 12;
  localparam int NS    = 4;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int FRAME = ROWS * COLS;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  crop_frame_arbiter_if #(.PIXEL_BIT_WIDTH(PW), .NUM_SRC(NS)) bus();

  crop_frame_arbiter #(
    .PIXEL_BIT_WIDTH(PW),
    .NUM_SRC        (NS),
    .IN_ROWS        (ROWS),
    .IN_COLS        (COLS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  int checks = 0;
  int errors = 0;
  int seq [NS];

  logic          o_valid, o_sof, o_busy, o_done;
  logic [PW-1:0] o_pixel;
  logic [NS-1:0] o_ready;
  logic [1:0]    o_id;

  typedef struct {
    int ticks;
    int idle;
    int idle_bad;
    int xfers;
    int sof_err;
    int pix_err;
    int id_err;
    int foreign;
    int gap_valid;
    int done_first;
    int done_mid;
  } frame_res_t;

  // Drive one cycle's inputs after the falling edge, then sample the combinational outputs.
  task automatic tick(input logic [NS-1:0] vmask, input bit rdy, input bit rst);
    @(negedge clk);
    reset           = rst;
    bus.src_valid   = vmask;
    bus.crop_ready  = rdy;
    for (int s = 0; s < NS; s++) bus.src_pixel[s*PW +: PW] = PW'(s*1024 + seq[s]);
    #1;
    o_valid = bus.crop_valid;
    o_sof   = bus.crop_sof;
    o_busy  = bus.busy;
    o_done  = bus.frame_done;
    o_pixel = bus.crop_pixel;
    o_ready = bus.src_ready;
    o_id    = bus.crop_src_id;
  endtask

  // Runs until max_xfers pixels of exp_id have transferred (or 200 cycles), tallying anomalies.
  task automatic run_frame(input int exp_id, input logic [NS-1:0] base_mask, input int max_xfers,
                           input int gap_after, input int gap_len, input bit toggle,
                           output frame_res_t r);
    logic [NS-1:0] m;
    bit            rdy;
    bit            in_gap;
    int            gap_left;
    r        = '{default: 0};
    gap_left = gap_len;
    while (r.xfers < max_xfers && r.ticks < 200) begin
      m      = base_mask;
      in_gap = 1'b0;
      if (gap_after >= 0 && r.xfers == gap_after && gap_left > 0) begin
        in_gap    = 1'b1;
        gap_left -= 1;
        m[exp_id] = 1'b0;
      end
      rdy = toggle ? (r.ticks % 2 == 0) : 1'b1;
      tick(m, rdy, 1'b0);
      if (r.ticks == 0) r.done_first = int'(o_done);
      else if (o_done)  r.done_mid++;
      r.ticks++;
      if (!o_busy) begin
        r.idle++;
        if (o_valid || o_sof || o_ready != '0) r.idle_bad++;
      end else begin
        if (o_id !== 2'(exp_id)) r.id_err++;
        if ((o_ready & ~(4'b0001 << exp_id)) != '0 || o_ready[exp_id] !== rdy) r.foreign++;
        if (in_gap && o_valid) r.gap_valid++;
        if (o_sof !== (o_valid && r.xfers == 0)) r.sof_err++;
        if (o_valid && rdy) begin
          if (o_pixel !== PW'(exp_id*1024 + seq[exp_id])) r.pix_err++;
          seq[exp_id]++;
          r.xfers++;
        end
      end
    end
  endtask

  function automatic int err_sum(input frame_res_t r);
    return r.idle_bad + r.sof_err + r.pix_err + r.id_err + r.foreign + r.done_mid;
  endfunction

  task automatic test_reset();
    tick('0, 1'b1, 1'b1);
    tick('0, 1'b1, 1'b1);
    tick('0, 1'b1, 1'b0);
    checks++; if (o_busy  !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
    checks++; if (o_sof   !== 1'b0) begin errors++; $display("FAIL reset_sof got %b want 0", o_sof); end
    checks++; if (o_ready !== 4'b0) begin errors++; $display("FAIL reset_ready got %b want 0000", o_ready); end
    checks++; if (o_id    !== 2'd0) begin errors++; $display("FAIL reset_id got %0d want 0", o_id); end
    checks++; if (o_done  !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", o_done); end
  endtask

  task automatic test_two_sources();
    frame_res_t r;
    run_frame(1, 4'b1010, FRAME, -1, 0, 1'b0, r);
    checks++; if (r.xfers != FRAME) begin errors++; $display("FAIL two_src1_xfers got %0d want %0d", r.xfers, FRAME); end
    checks++; if (r.idle != 1) begin errors++; $display("FAIL two_src1_idle got %0d want 1", r.idle); end
    checks++; if (err_sum(r) != 0) begin errors++; $display("FAIL two_src1_errs got %0d want 0", err_sum(r)); end
    run_frame(3, 4'b1010, FRAME, -1, 0, 1'b0, r);
    checks++; if (r.xfers != FRAME) begin errors++; $display("FAIL two_src3_xfers got %0d want %0d", r.xfers, FRAME); end
    checks++; if (r.idle != 1) begin errors++; $display("FAIL two_src3_idle got %0d want 1", r.idle); end
    checks++; if (r.done_first != 1) begin errors++; $display("FAIL two_src3_done got %0d want 1", r.done_first); end
    checks++; if (err_sum(r) != 0) begin errors++; $display("FAIL two_src3_errs got %0d want 0", err_sum(r)); end
    tick('0, 1'b1, 1'b0);
    checks++; if (o_done !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL two_end_done got done=%b busy=%b want 1 0", o_done, o_busy); end
    checks++; if (o_id !== 2'd3) begin errors++; $display("FAIL two_id_hold got %0d want 3", o_id); end
    tick('0, 1'b1, 1'b0);
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL two_done_pulse got %b want 0", o_done); end
  endtask

  task automatic test_round_robin();
    frame_res_t r;
    int         order [5] = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      run_frame(order[k], 4'b1111, FRAME, -1, 0, 1'b0, r);
      checks++; if (r.xfers != FRAME || r.idle != 1) begin errors++; $display("FAIL rr%0d_frame got xfers=%0d idle=%0d want %0d 1", k, r.xfers, r.idle, FRAME); end
      checks++; if (err_sum(r) != 0) begin errors++; $display("FAIL rr%0d_errs got %0d want 0 (src %0d)", k, err_sum(r), order[k]); end
      checks++; if (r.done_first != int'(k > 0)) begin errors++; $display("FAIL rr%0d_done got %0d want %0d", k, r.done_first, int'(k > 0)); end
    end
    tick('0, 1'b1, 1'b0);
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL rr_end_done got %b want 1", o_done); end
  endtask

  task automatic test_stall();
    frame_res_t r;
    run_frame(1, 4'b1111, FRAME, 8, 3, 1'b0, r);
    checks++; if (r.xfers != FRAME) begin errors++; $display("FAIL stall_xfers got %0d want %0d", r.xfers, FRAME); end
    checks++; if (r.gap_valid != 0) begin errors++; $display("FAIL stall_gap_valid got %0d want 0", r.gap_valid); end
    checks++; if (r.ticks != 1 + FRAME + 3) begin errors++; $display("FAIL stall_ticks got %0d want %0d", r.ticks, 1 + FRAME + 3); end
    checks++; if (err_sum(r) != 0) begin errors++; $display("FAIL stall_errs got %0d want 0", err_sum(r)); end
    tick('0, 1'b1, 1'b0);
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL stall_done got %b want 1", o_done); end
  endtask

  task automatic test_ready_toggle();
    frame_res_t r;
    run_frame(2, 4'b1111, FRAME, -1, 0, 1'b1, r);
    checks++; if (r.xfers != FRAME) begin errors++; $display("FAIL toggle_xfers got %0d want %0d", r.xfers, FRAME); end
    checks++; if (r.ticks != 1 + 2*FRAME) begin errors++; $display("FAIL toggle_ticks got %0d want %0d", r.ticks, 1 + 2*FRAME); end
    checks++; if (err_sum(r) != 0) begin errors++; $display("FAIL toggle_errs got %0d want 0", err_sum(r)); end
    tick('0, 1'b1, 1'b0);
    checks++; if (o_done !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL toggle_done got done=%b busy=%b want 1 0", o_done, o_busy); end
    tick('0, 1'b1, 1'b0);
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL toggle_done_pulse got %b want 0", o_done); end
  endtask

  task automatic test_reset_mid_frame();
    frame_res_t r;
    run_frame(2, 4'b0100, 9, -1, 0, 1'b0, r);
    checks++; if (r.xfers != 9 || err_sum(r) != 0) begin errors++; $display("FAIL rstmid_pre got xfers=%0d errs=%0d want 9 0", r.xfers, err_sum(r)); end
    tick(4'b0101, 1'b1, 1'b1);
    tick(4'b0101, 1'b1, 1'b0);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", o_busy); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", o_done); end
    checks++; if (o_ready !== 4'b0 || o_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ready got ready=%b valid=%b want 0000 0", o_ready, o_valid); end
    run_frame(0, 4'b0101, FRAME, -1, 0, 1'b0, r);
    checks++; if (r.xfers != FRAME || r.idle != 0) begin errors++; $display("FAIL rstmid_src0 got xfers=%0d idle=%0d want %0d 0", r.xfers, r.idle, FRAME); end
    checks++; if (err_sum(r) != 0) begin errors++; $display("FAIL rstmid_errs got %0d want 0", err_sum(r)); end
    tick('0, 1'b1, 1'b0);
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL rstmid_end_done got %b want 1", o_done); end
  endtask

  task automatic test_single_source();
    frame_res_t r;
    for (int k = 0; k < 3; k++) begin
      run_frame(2, 4'b0100, FRAME, -1, 0, 1'b0, r);
      checks++; if (r.xfers != FRAME || r.idle != 1) begin errors++; $display("FAIL single%0d_frame got xfers=%0d idle=%0d want %0d 1", k, r.xfers, r.idle, FRAME); end
      checks++; if (err_sum(r) != 0) begin errors++; $display("FAIL single%0d_errs got %0d want 0", k, err_sum(r)); end
      checks++; if (r.done_first != int'(k > 0)) begin errors++; $display("FAIL single%0d_done got %0d want %0d", k, r.done_first, int'(k > 0)); end
    end
    tick('0, 1'b1, 1'b0);
    checks++; if (o_done !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL single_end got done=%b busy=%b want 1 0", o_done, o_busy); end
  endtask

  initial begin
    reset          = 1'b1;
    bus.src_valid  = '0;
    bus.src_pixel  = '0;
    bus.crop_ready = 1'b0;
    for (int s = 0; s < NS; s++) seq[s] = 0;
    test_reset();
    test_two_sources();
    test_round_robin();
    test_stall();
    test_ready_toggle();
    test_reset_mid_frame();
    test_single_source();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
